// File: rtl/sata_crc_pkg.sv
// Shared constants and the CRC-32 step function for the SATA frame CRC.
package sata_crc_pkg;

    localparam int unsigned CRC_W = 32;

    localparam logic [CRC_W-1:0] CRC_INIT = 32'h5232_5032;
    localparam logic [CRC_W-1:0] CRC_POLY = 32'h04C1_1DB7;

    // One dword step: ((crc ^ data) * x^32) mod P, bit 31 entering first.
    // The loop unrolls into a flat XOR network at elaboration.
    function automatic logic [CRC_W-1:0] crc32_step(
        input logic [CRC_W-1:0] crc,
        input logic [CRC_W-1:0] data,
        input logic [CRC_W-1:0] poly = CRC_POLY
    );
        logic [CRC_W-1:0] c;
        c = crc ^ data;
        for (int i = 0; i < int'(CRC_W); i++) begin
            if (c[CRC_W-1]) begin
                c = (c << 1) ^ poly;
            end else begin
                c = c << 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/sata_crc.sv
// Running SATA CRC-32 over descrambled payload dwords, one dword per cycle.
module sata_crc
    import sata_crc_pkg::*;
#(
    parameter logic [31:0] C_CRC_INIT = CRC_INIT,
    parameter logic [31:0] C_CRC_POLY = CRC_POLY
) (
    input  logic        clk_75m,
    input  logic        rst_n,
    input  logic        crc_rst,
    input  logic        data_valid,
    input  logic [31:0] data_in,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q;
    logic [31:0] crc_next_c;

    // Single-cycle parallel XOR network for the next register value.
    always_comb begin
        crc_next_c = crc32_step(crc_q, data_in, C_CRC_POLY);
    end

    // CRC register: frame-start clear wins over data, idle cycles hold.
    always_ff @(posedge clk_75m or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= C_CRC_INIT;
        end else if (crc_rst) begin
            crc_q <= C_CRC_INIT;
        end else if (data_valid) begin
            crc_q <= crc_next_c;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: tb/tb_sata_crc.sv
// Randomized self-checking bench for sata_crc against a polynomial-division model.
module tb_sata_crc;

    localparam logic [31:0] INIT = 32'h5232_5032;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic        clk_75m;
    logic        rst_n;
    logic        crc_rst;
    logic        data_valid;
    logic [31:0] data_in;
    logic [31:0] crc_out;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_crc;
    logic [31:0] frame [0:2047];

    sata_crc dut (
        .clk_75m    (clk_75m),
        .rst_n      (rst_n),
        .crc_rst    (crc_rst),
        .data_valid (data_valid),
        .data_in    (data_in),
        .crc_out    (crc_out)
    );

    initial clk_75m = 1'b0;
    always #5 clk_75m = ~clk_75m;

    // Reference: remainder of the 64-bit polynomial (crc ^ data) * x^32 divided by P.
    function automatic logic [31:0] ref_step(input logic [31:0] crc, input logic [31:0] data);
        logic [63:0] v;
        logic [63:0] divisor;
        v       = {crc ^ data, 32'h0};
        divisor = {31'h0, 1'b1, POLY};
        for (int i = 63; i >= 32; i--) begin
            if (v[i]) v = v ^ (divisor << (i - 32));
        end
        return v[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle from a falling edge, return on the next falling edge with the model updated.
    task automatic step(input logic v, input logic r, input logic [31:0] d);
        data_valid = v;
        crc_rst    = r;
        data_in    = d;
        @(posedge clk_75m);
        @(negedge clk_75m);
        if (r) exp_crc = INIT;
        else if (v) exp_crc = ref_step(exp_crc, d);
    endtask

    // Clear, then feed frame[0:len-1] back to back, checking every cycle.
    task automatic feed_frame(input int len, input string tag);
        step(1'b0, 1'b1, $urandom);
        check({tag, "_clear"}, crc_out, INIT);
        for (int i = 0; i < len; i++) begin
            step(1'b1, 1'b0, frame[i]);
            check(tag, crc_out, exp_crc);
        end
    endtask

    initial begin
        logic [31:0] ref_final;
        logic [31:0] good;
        logic [31:0] held;
        int          len;
        int          pos [4];

        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        crc_rst    = 1'b0;
        data_valid = 1'b0;
        data_in    = 32'h0;
        exp_crc    = INIT;

        // Asynchronous reset with no clock edge involved.
        #1 rst_n = 1'b0;
        #1 check("reset_state", crc_out, INIT);
        @(negedge clk_75m);
        rst_n = 1'b1;

        // Idle cycle holds and ignores data_in.
        step(1'b0, 1'b0, 32'hDEAD_BEEF);
        check("idle_hold", crc_out, INIT);

        // INIT dword cancels the register, zero keeps it at zero.
        step(1'b1, 1'b0, INIT);
        check("init_dword_zero", crc_out, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        check("zero_stays_zero", crc_out, 32'h0);

        // Accumulate something, then crc_rst together with valid.
        step(1'b1, 1'b0, $urandom);
        check("pre_rst_data", crc_out, exp_crc);
        step(1'b1, 1'b1, $urandom);
        check("rst_priority", crc_out, INIT);

        // Random frames including both length extremes, then residue check.
        for (int f = 0; f < 4; f++) begin
            len = (f == 0) ? 1 : (f == 1) ? 2048 : $urandom_range(2, 300);
            for (int i = 0; i < len; i++) frame[i] = $urandom;
            feed_frame(len, "frame");
            step(1'b1, 1'b0, exp_crc);
            check("frame_residue", crc_out, 32'h0);
        end

        // Gap-free reference run, then the same frame with random idle gaps.
        len = 64;
        for (int i = 0; i < len; i++) frame[i] = $urandom;
        feed_frame(len, "gapfree");
        ref_final = crc_out;
        step(1'b0, 1'b1, $urandom);
        for (int i = 0; i < len; i++) begin
            held = exp_crc;
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                step(1'b0, 1'b0, $urandom);
                check("gap_hold", crc_out, held);
            end
            step(1'b1, 1'b0, frame[i]);
            check("gap_frame", crc_out, exp_crc);
        end
        check("gap_final", crc_out, ref_final);

        // Reset mid-frame, asserted between edges, then restart.
        step(1'b1, 1'b0, $urandom);
        step(1'b1, 1'b0, $urandom);
        #2 rst_n = 1'b0;
        #1 check("async_midframe", crc_out, INIT);
        @(negedge clk_75m);
        rst_n   = 1'b1;
        exp_crc = INIT;
        step(1'b1, 1'b0, $urandom);
        check("after_reset_data", crc_out, exp_crc);

        // Single-bit flips at 4 positions of a 16-dword frame.
        len = 16;
        for (int i = 0; i < len; i++) frame[i] = $urandom;
        good = INIT;
        for (int i = 0; i < len; i++) good = ref_step(good, frame[i]);
        pos[0] = 0;
        pos[1] = $urandom_range(1, 7);
        pos[2] = $urandom_range(8, 14);
        pos[3] = 15;
        for (int p = 0; p < 4; p++) begin
            for (int b = 0; b < 32; b++) begin
                frame[pos[p]][b] = ~frame[pos[p]][b];
                feed_frame(len, "flip_frame");
                check("flip_differs", 32'(crc_out !== good), 32'h1);
                frame[pos[p]][b] = ~frame[pos[p]][b];
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
